ps2_tx_funcmod: RTL

PS2_TX_FUNCMOD -- requirements
Module: ps2_tx_funcmod

---
 rtl/ps2_tx_funcmod.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_tx_funcmod.sv
// ---------------------------------------------------------------------------
// ps2_tx_funcmod
//   Host-to-device PS/2 command transmitter. Holds the clock line low for an
//   inhibit period, asserts the start bit, then shifts out 8 data bits (LSB
//   first), odd parity and the stop bit on the device-generated clock. The
//   device ack is sampled on the 11th falling edge. A watchdog aborts the
//   transfer when the device stops clocking.
//
//   Ports
//     CLOCK       system clock, all state updates on the rising edge
//     RST         asynchronous active-high reset
//     iTrig       one-cycle command request, iData captured in the same cycle
//     iData[7:0]  command byte
//     PS2_CLK_IN  sensed PS/2 clock line (asynchronous)
//     PS2_DAT_IN  sensed PS/2 data line (asynchronous)
//     PS2_CLK_OE  1 = pull clock line low, 0 = release
//     PS2_DAT_OE  1 = pull data line low, 0 = release
//     oBusy       transfer in progress
//     oDone       one-cycle end-of-transfer pulse
//     oErr[1:0]   00 acked, 01 no ack, 10 timeout; valid with oDone, held after
// ---------------------------------------------------------------------------
module ps2_tx_funcmod #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 750_000
) (
   input  logic       CLOCK,
   input  logic       RST,
   input  logic       iTrig,
   input  logic [7:0] iData,
   input  logic       PS2_CLK_IN,
   input  logic       PS2_DAT_IN,
   output logic       PS2_CLK_OE,
   output logic       PS2_DAT_OE,
   output logic       oBusy,
   output logic       oDone,
   output logic [1:0] oErr
);

   localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC + 1) : 1;
   localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   // Elaboration-time guard against nonsensical parameter values.
   if (CLK_FREQ <= 0 || INHIBIT_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("ps2_tx_funcmod: invalid parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_SHIFT,
      S_WAIT_IDLE,
      S_DONE
   } state_t;

   // -----------------------------------------------------------------------
   // Two-flop synchronizers for both lines (index 0 = clock, 1 = data).
   // -----------------------------------------------------------------------
   logic [1:0] line_in;
   logic [1:0] line_s;
   assign line_in = {PS2_DAT_IN, PS2_CLK_IN};

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [1:0] sh_reg;
      always_ff @(posedge CLOCK or posedge RST) begin
         if (RST) sh_reg <= 2'b11;
         else     sh_reg <= {sh_reg[0], line_in[gi]};
      end
      assign line_s[gi] = sh_reg[1];
   end

   // Previous synchronized clock value for falling-edge detection.
   logic clk_prev_reg;
   logic clk_fall;
   always_ff @(posedge CLOCK or posedge RST) begin
      if (RST) clk_prev_reg <= 1'b1;
      else     clk_prev_reg <= line_s[0];
   end
   assign clk_fall = clk_prev_reg & ~line_s[0];

   // -----------------------------------------------------------------------
   // Transfer state
   // -----------------------------------------------------------------------
   state_t            state_reg,   state_next;
   logic [7:0]        data_reg,    data_next;
   logic              parity_reg,  parity_next;
   logic [3:0]        bit_cnt_reg, bit_cnt_next;
   logic [INH_W-1:0]  inh_cnt_reg, inh_cnt_next;
   logic [TO_W-1:0]   to_cnt_reg,  to_cnt_next;
   logic              ack_reg,     ack_next;
   logic              clk_oe_reg,  clk_oe_next;
   logic              dat_oe_reg,  dat_oe_next;
   logic [1:0]        err_reg,     err_next;
   logic              to_hit;

   always_ff @(posedge CLOCK or posedge RST) begin
      if (RST) begin
         state_reg   <= S_IDLE;
         data_reg    <= '0;
         parity_reg  <= 1'b0;
         bit_cnt_reg <= '0;
         inh_cnt_reg <= '0;
         to_cnt_reg  <= '0;
         ack_reg     <= 1'b0;
         clk_oe_reg  <= 1'b0;
         dat_oe_reg  <= 1'b0;
         err_reg     <= 2'b00;
      end else begin
         state_reg   <= state_next;
         data_reg    <= data_next;
         parity_reg  <= parity_next;
         bit_cnt_reg <= bit_cnt_next;
         inh_cnt_reg <= inh_cnt_next;
         to_cnt_reg  <= to_cnt_next;
         ack_reg     <= ack_next;
         clk_oe_reg  <= clk_oe_next;
         dat_oe_reg  <= dat_oe_next;
         err_reg     <= err_next;
      end
   end

   // The watchdog fires in the cycle the counter shows TIMEOUT_CYC-1, so the
   // lines are released exactly TIMEOUT_CYC cycles after the last clear.
   assign to_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_next   = state_reg;
      data_next    = data_reg;
      parity_next  = parity_reg;
      bit_cnt_next = bit_cnt_reg;
      inh_cnt_next = inh_cnt_reg;
      to_cnt_next  = to_cnt_reg;
      ack_next     = ack_reg;
      clk_oe_next  = clk_oe_reg;
      dat_oe_next  = dat_oe_reg;
      err_next     = err_reg;

      case (state_reg)
         S_IDLE: begin
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
            if (iTrig) begin
               data_next    = iData;
               parity_next  = ~^iData;
               bit_cnt_next = '0;
               inh_cnt_next = '0;
               clk_oe_next  = 1'b1;
               state_next   = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 1)) begin
               dat_oe_next = 1'b1;
               state_next  = S_START;
            end else begin
               inh_cnt_next = inh_cnt_reg + INH_W'(1);
            end
         end

         S_START: begin
            // Release the clock; data stays low (start bit) until edge 1.
            clk_oe_next = 1'b0;
            to_cnt_next = '0;
            state_next  = S_SHIFT;
         end

         S_SHIFT: begin
            if (to_hit) begin
               clk_oe_next = 1'b0;
               dat_oe_next = 1'b0;
               err_next    = 2'b10;
               state_next  = S_DONE;
            end else begin
               to_cnt_next = to_cnt_reg + TO_W'(1);
               if (clk_fall) begin
                  to_cnt_next = '0;
                  if (bit_cnt_reg != 4'hF)
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  // bit_cnt_reg holds the number of edges already seen.
                  if (bit_cnt_reg < 4'd8) begin
                     dat_oe_next = ~data_reg[bit_cnt_reg[2:0]];
                  end else if (bit_cnt_reg == 4'd8) begin
                     dat_oe_next = ~parity_reg;
                  end else if (bit_cnt_reg == 4'd9) begin
                     dat_oe_next = 1'b0;
                  end else begin
                     ack_next    = ~line_s[1];
                     dat_oe_next = 1'b0;
                     state_next  = S_WAIT_IDLE;
                  end
               end
            end
         end

         S_WAIT_IDLE: begin
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
            if (to_hit) begin
               err_next   = 2'b10;
               state_next = S_DONE;
            end else begin
               to_cnt_next = clk_fall ? '0 : to_cnt_reg + TO_W'(1);
               if (line_s == 2'b11) begin
                  err_next   = ack_reg ? 2'b00 : 2'b01;
                  state_next = S_DONE;
               end
            end
         end

         S_DONE: begin
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
            state_next  = S_IDLE;
         end

         default: begin
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
            state_next  = S_IDLE;
         end
      endcase
   end

   assign PS2_CLK_OE = clk_oe_reg;
   assign PS2_DAT_OE = dat_oe_reg;
   assign oBusy      = (state_reg != S_IDLE);
   assign oDone      = (state_reg == S_DONE);
   assign oErr       = err_reg;

endmodule
